// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: pattern modes and ping-pong FSM states.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT    = 2'b00,
        MODE_ROTATE   = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    typedef enum logic {
        GO_LEFT  = 1'b0,
        GO_RIGHT = 1'b1
    } pp_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts enabled clocks and flags a step when the count reaches i_period.
module tick_gen #(
    parameter int NB_PERIOD = 24
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [NB_PERIOD-1:0] i_period,
    input  logic                 i_clear,
    output logic                 o_tick
);

    logic [NB_PERIOD-1:0] cnt_q, cnt_d;

    // >= rather than == so that lowering i_period below the count steps right away.
    assign o_tick = i_enable & ~i_clear & (cnt_q >= i_period);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || o_tick)
            cnt_d = '0;
        else if (i_enable)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: shift / rotate / ping-pong / hold, advanced by a programmable prescaler.
module led_sequencer
    import led_pkg::*;
#(
    parameter int NB_LEDS   = 4,
    parameter int NB_PERIOD = 24
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [1:0]           i_mode,
    input  logic                 i_dir,
    input  logic [NB_PERIOD-1:0] i_period,
    input  logic                 i_load,
    input  logic [NB_LEDS-1:0]   i_pattern,
    output logic [NB_LEDS-1:0]   o_led,
    output logic                 o_tick,
    output logic                 o_wrap
);

    localparam logic [NB_LEDS-1:0] SEED_L = {{(NB_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NB_LEDS-1:0] SEED_R = {1'b1, {(NB_LEDS-1){1'b0}}};

    pp_state_e            state_q, state_d;
    logic [NB_LEDS-1:0]   led_q, led_d;
    logic                 tick_q, tick_d;
    logic                 wrap_q, wrap_d;
    logic                 step;
    logic [NB_LEDS-1:0]   shl, shr, rotl, rotr;
    mode_e                mode;

    tick_gen #(
        .NB_PERIOD (NB_PERIOD)
    ) u_tick_gen (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_period (i_period),
        .i_clear  (i_load),
        .o_tick   (step)
    );

    assign mode = mode_e'(i_mode);
    assign shl  = {led_q[NB_LEDS-2:0], 1'b0};
    assign shr  = {1'b0, led_q[NB_LEDS-1:1]};
    assign rotl = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
    assign rotr = {led_q[0], led_q[NB_LEDS-1:1]};

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (i_load) begin
            // An all-zero load would leave every LED dark forever, so substitute the seed.
            led_d   = (i_pattern == '0) ? SEED_L : i_pattern;
            state_d = GO_LEFT;
        end else if (step) begin
            tick_d = 1'b1;
            case (mode)
                MODE_SHIFT: begin
                    if (i_dir == DIR_LEFT) begin
                        led_d  = (shl == '0) ? SEED_L : shl;
                        wrap_d = (shl == '0);
                    end else begin
                        led_d  = (shr == '0) ? SEED_R : shr;
                        wrap_d = (shr == '0);
                    end
                end
                MODE_ROTATE: begin
                    if (i_dir == DIR_LEFT) begin
                        led_d  = rotl;
                        wrap_d = led_q[NB_LEDS-1];
                    end else begin
                        led_d  = rotr;
                        wrap_d = led_q[0];
                    end
                end
                MODE_PINGPONG: begin
                    if (state_q == GO_LEFT) begin
                        if (led_q[NB_LEDS-1]) begin
                            state_d = GO_RIGHT;
                            led_d   = shr;
                            wrap_d  = 1'b1;
                        end else begin
                            led_d   = shl;
                        end
                    end else begin
                        if (led_q[0]) begin
                            state_d = GO_LEFT;
                            led_d   = shl;
                            wrap_d  = 1'b1;
                        end else begin
                            led_d   = shr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) state_q <= GO_LEFT;
        else         state_q <= state_d;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            led_q  <= SEED_L;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign o_led  = led_q;
    assign o_tick = tick_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (NB_LEDS=4) with hand-computed expectations.
module tb_led_sequencer;

    logic        clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [1:0]  i_mode;
    logic        i_dir;
    logic [23:0] i_period;
    logic        i_load;
    logic [3:0]  i_pattern;
    logic [3:0]  o_led;
    logic        o_tick;
    logic        o_wrap;

    int n_cmp = 0;
    int n_err = 0;

    led_sequencer #(.NB_LEDS(4), .NB_PERIOD(24)) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_mode    (i_mode),
        .i_dir     (i_dir),
        .i_period  (i_period),
        .i_load    (i_load),
        .i_pattern (i_pattern),
        .o_led     (o_led),
        .o_tick    (o_tick),
        .o_wrap    (o_wrap)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] led, input logic tick, input logic wrap);
        chk({tag, ".led"},  32'(o_led),  32'(led));
        chk({tag, ".tick"}, 32'(o_tick), 32'(tick));
        chk({tag, ".wrap"}, 32'(o_wrap), 32'(wrap));
    endtask

    logic [3:0] rot_led [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       rot_wrap[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] sh_led  [4]  = '{4'b0101, 4'b0010, 4'b0001, 4'b1000};
    logic       sh_wrap [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] pp_led  [7]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic       pp_wrap [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int s;
        i_reset   = 1'b1;
        i_enable  = 1'b0;
        i_mode    = 2'b01;
        i_dir     = 1'b0;
        i_period  = 24'd2;
        i_load    = 1'b0;
        i_pattern = 4'b0000;
        #2;
        chk_out("reset", 4'b0001, 1'b0, 1'b0);
        clk1();
        clk1();
        i_reset  = 1'b0;
        i_enable = 1'b1;

        // ROTATE left, period 2: step every 3rd clock
        s = 0;
        for (int k = 1; k <= 12; k++) begin
            clk1();
            if (k % 3 == 0) begin
                chk_out($sformatf("rot%0d", k), rot_led[s], 1'b1, rot_wrap[s]);
                s++;
            end else begin
                chk_out($sformatf("rot%0d", k), (s == 0) ? 4'b0001 : rot_led[s-1], 1'b0, 1'b0);
            end
        end

        // enable dropped mid-period: count=1 is preserved
        clk1();
        i_enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            clk1();
            chk(.tag($sformatf("frz%0d.tick", k)), .got(32'(o_tick)), .exp(32'd0));
        end
        chk("frz.led", 32'(o_led), 32'h1);
        i_enable = 1'b1;
        clk1();
        chk_out("resume1", 4'b0001, 1'b0, 1'b0);
        clk1();
        chk_out("resume2", 4'b0010, 1'b1, 1'b0);

        // zero load on what would be a step edge
        clk1();
        clk1();
        i_load    = 1'b1;
        i_pattern = 4'b0000;
        clk1();
        chk_out("ld0", 4'b0001, 1'b0, 1'b0);
        i_load = 1'b0;
        clk1();
        chk_out("ld0+1", 4'b0001, 1'b0, 1'b0);
        clk1();
        chk_out("ld0+2", 4'b0001, 1'b0, 1'b0);
        clk1();
        chk_out("ld0+3", 4'b0010, 1'b1, 1'b0);

        // SHIFT right from 1010, period 0
        i_mode    = 2'b00;
        i_dir     = 1'b1;
        i_period  = 24'd0;
        i_load    = 1'b1;
        i_pattern = 4'b1010;
        clk1();
        chk_out("ld1010", 4'b1010, 1'b0, 1'b0);
        i_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            clk1();
            chk_out($sformatf("sh%0d", k), sh_led[k], 1'b1, sh_wrap[k]);
        end

        // reset asserted between edges
        i_reset = 1'b1;
        #2;
        chk_out("areset", 4'b0001, 1'b0, 1'b0);
        i_mode = 2'b10;
        clk1();
        i_reset = 1'b0;

        // PINGPONG from reset, period 0
        for (int k = 0; k < 7; k++) begin
            clk1();
            chk_out($sformatf("pp%0d", k), pp_led[k], 1'b1, pp_wrap[k]);
        end

        // HOLD, period 1: ticks continue, pattern frozen
        i_mode   = 2'b11;
        i_period = 24'd1;
        for (int k = 0; k < 4; k++) begin
            clk1();
            chk_out($sformatf("hold%0d", k), 4'b0010, (k % 2) == 1, 1'b0);
        end

        // lowering the period below the count forces an immediate step
        i_mode   = 2'b01;
        i_dir    = 1'b1;
        i_period = 24'd5;
        for (int k = 0; k < 3; k++) begin
            clk1();
            chk_out($sformatf("long%0d", k), 4'b0010, 1'b0, 1'b0);
        end
        i_period = 24'd1;
        clk1();
        chk_out("lower", 4'b0001, 1'b1, 1'b0);
        clk1();
        chk_out("lower+1", 4'b0001, 1'b0, 1'b0);
        clk1();
        chk_out("rotr_wrap", 4'b1000, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter NB_LEDS, default 4: LED register width; SHALL be >= 2.
REQ-002 Parameter NB_PERIOD, default 24: prescaler counter and i_period width.
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port i_reset  input  1  asynchronous, active-high reset.
REQ-005 Port i_enable  input  1  1 = prescaler runs; 0 = prescaler and pattern frozen.
REQ-006 Port i_mode  input  2  00 SHIFT, 01 ROTATE, 10 PINGPONG, 11 HOLD.
REQ-007 Port i_dir  input  1  0 = toward MSB (left), 1 = toward LSB (right); ignored in PINGPONG and HOLD.
REQ-008 Port i_period  input  NB_PERIOD  step period minus one, in clocks.
REQ-009 Port i_load  input  1  load i_pattern this cycle.
REQ-010 Port i_pattern  input  NB_LEDS  pattern loaded on i_load.
REQ-011 Port o_led  output  NB_LEDS  registered LED pattern.
REQ-012 Port o_tick  output  1  registered one-cycle pulse on each step edge.
REQ-013 Port o_wrap  output  1  registered one-cycle pulse on reseed, end-of-ring, or reversal.

Function
REQ-014 Prescaler: when i_enable=1, cnt increments each clock; when cnt >= i_period, cnt <= 0 and a step occurs on the same edge.
REQ-015 With i_period=0, a step SHALL occur every enabled clock; lowering i_period below cnt SHALL cause a step on the next enabled edge.
REQ-016 On a step edge: o_tick <= 1 and o_led <= next pattern on that same edge. On all other edges: o_tick <= 0 and o_wrap <= 0.
REQ-017 SHIFT: shift one position per i_dir with zero fill; a zero result reloads the seed instead (0...01 for left, 10...0 for right), with o_wrap <= 1.
REQ-018 ROTATE: circular rotate by one per i_dir; o_wrap <= 1 when the bit leaving (MSB for left, LSB for right) is 1.
REQ-019 PINGPONG: FSM states GO_LEFT and GO_RIGHT.
  - GO_LEFT with o_led[MSB]=0: shift left, zero fill.
  - GO_LEFT with o_led[MSB]=1: go to GO_RIGHT, shift right, o_wrap <= 1.
  - GO_RIGHT is the mirror case, using o_led[0].
REQ-020 HOLD: prescaler runs and o_tick pulses; o_led and FSM state are unchanged; o_wrap stays 0.
REQ-021 i_load=1 has priority over a step. On that edge:
  - o_led <= i_pattern, or 0...01 if i_pattern is all zero;
  - cnt <= 0, FSM <= GO_LEFT, o_tick <= 0, o_wrap <= 0.
  i_load acts regardless of i_enable.
REQ-022 i_enable=0: cnt, o_led and FSM hold; o_tick and o_wrap are 0.
REQ-023 Changes to i_mode or i_dir take effect at the next step; FSM state is retained across mode changes.
REQ-024 o_led SHALL never be all zero outside reset.

Reset
REQ-025 i_reset=1 SHALL, without waiting for a clock edge, set o_led=0...01, cnt=0, o_tick=0, o_wrap=0, FSM=GO_LEFT.
REQ-026 The first step after reset release SHALL occur i_period+1 enabled clocks later.

Structure
REQ-027 Mode encodings and FSM state encodings SHALL be constants in a shared package, led_pkg.
REQ-028 The prescaler SHALL be a sub-module, tick_gen, with inputs clock, i_reset, i_enable, i_period, i_clear and output o_tick.
REQ-029 All outputs SHALL be driven directly from flops.

Verification (NB_LEDS=4)
REQ-030 ROTATE, i_dir=0, i_period=2, enable after reset: o_led 0001→0010→0100→1000→0001, one step every 3 clocks; o_wrap only on 1000→0001.
REQ-031 Load 1010, SHIFT, i_dir=1, i_period=0: o_led 0101→0010→0001→1000; o_wrap on the 1000 step only.
REQ-032 PINGPONG from reset, i_period=0: o_led 0010, 0100, 1000, 0100, 0010, 0001, 0010; o_wrap on the 1000→0100 and 0001→0010 steps.
REQ-033 i_load with i_pattern=0000 on a step edge: o_led=0001, no o_tick; next step occurs i_period+1 clocks later.
REQ-034 Assert i_reset between clock edges mid-run: o_led=0001 and o_tick=0 before the next edge.
REQ-035 Drop i_enable for 10 clocks mid-period: o_led frozen, no o_tick; remaining count resumes unchanged.
